// File: rtl/vproc_issue_scoreboard.sv
// Vector issue scoreboard: tracks in-flight instructions' vreg read/write
// masks, blocks RAW/WAR/WAW conflicts and feeds a one-deep dispatch register.

package vproc_issue_pkg;
    typedef enum logic [1:0] {
        UNIT_ALU  = 2'd0,
        UNIT_MUL  = 2'd1,
        UNIT_LSU  = 2'd2,
        UNIT_ELEM = 2'd3
    } op_unit;
endpackage

module vproc_issue_scoreboard
    import vproc_issue_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int ID_W         = 3
) (
    input  logic            clk_i,
    input  logic            async_rst_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  op_unit          instr_unit_i,
    input  logic [31:0]     instr_rd_hazards_i,
    input  logic [31:0]     instr_wr_hazards_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output op_unit          issue_unit_o,
    output logic [ID_W-1:0] issue_id_o,
    input  logic            rdone_valid_i,
    input  logic [ID_W-1:0] rdone_id_i,
    input  logic            wdone_valid_i,
    input  logic [ID_W-1:0] wdone_id_i,
    output logic [31:0]     pend_rd_o,
    output logic [31:0]     pend_wr_o,
    output logic            stall_o,
    output logic            idle_o
);

    // state      | meaning
    // ENT_FREE   | slot unused, masks ignored
    // ENT_ACTIVE | reads and writes outstanding, both masks block
    // ENT_WR_ONLY| reads released, only write mask blocks
    typedef enum logic [1:0] {
        ENT_FREE    = 2'd0,
        ENT_ACTIVE  = 2'd1,
        ENT_WR_ONLY = 2'd2
    } ent_state_t;

    ent_state_t              r_state     [MAX_INFLIGHT];
    ent_state_t              w_state_nxt [MAX_INFLIGHT];
    logic [31:0]             r_rd_mask   [MAX_INFLIGHT];
    logic [31:0]             r_wr_mask   [MAX_INFLIGHT];
    logic                    r_issue_valid;
    logic [ID_W-1:0]         r_issue_id;
    op_unit                  r_issue_unit;

    logic [31:0]             w_pend_rd;
    logic [31:0]             w_pend_wr;
    logic                    w_any_free;
    logic                    w_all_free;
    logic [ID_W-1:0]         w_free_idx;
    logic                    w_conflict;
    logic                    w_accept;
    logic [MAX_INFLIGHT-1:0] w_rhit;
    logic [MAX_INFLIGHT-1:0] w_whit;

    // Pending masks and lowest free slot, from registered state only
    always_comb begin
        w_pend_rd  = '0;
        w_pend_wr  = '0;
        w_any_free = 1'b0;
        w_all_free = 1'b1;
        w_free_idx = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (r_state[i] == ENT_ACTIVE) begin
                w_pend_rd = w_pend_rd | r_rd_mask[i];
            end
            if (r_state[i] != ENT_FREE) begin
                w_pend_wr  = w_pend_wr | r_wr_mask[i];
                w_all_free = 1'b0;
            end else begin
                w_any_free = 1'b1;
                w_free_idx = ID_W'(i);
            end
        end
    end

    // The incoming instruction's own masks never meet each other here, so
    // self-overlap cannot stall it
    assign w_conflict = |((instr_rd_hazards_i & w_pend_wr) |
                          (instr_wr_hazards_i & w_pend_wr) |
                          (instr_wr_hazards_i & w_pend_rd));
    assign w_accept   = instr_valid_i & ~w_conflict & w_any_free &
                        (~r_issue_valid | issue_ready_i);

    // Release decode; out-of-range IDs never match a slot index
    always_comb begin
        w_rhit = '0;
        w_whit = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            w_rhit[i] = rdone_valid_i && (rdone_id_i == ID_W'(i));
            w_whit[i] = wdone_valid_i && (wdone_id_i == ID_W'(i));
        end
    end

    // Per-entry next state: allocate, partial release, retire
    always_comb begin
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ENT_FREE: begin
                    if (w_accept && (w_free_idx == ID_W'(i))) begin
                        w_state_nxt[i] = ENT_ACTIVE;
                    end
                end
                ENT_ACTIVE: begin
                    if (w_whit[i]) begin
                        w_state_nxt[i] = ENT_FREE;
                    end else if (w_rhit[i]) begin
                        w_state_nxt[i] = ENT_WR_ONLY;
                    end
                end
                ENT_WR_ONLY: begin
                    if (w_whit[i]) begin
                        w_state_nxt[i] = ENT_FREE;
                    end
                end
                default: w_state_nxt[i] = ENT_FREE;
            endcase
        end
    end

    // Entry state register
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                r_state[i] <= ENT_FREE;
            end
        end else begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Capture the hazard masks into the slot being allocated
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                r_rd_mask[i] <= '0;
                r_wr_mask[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (w_free_idx == ID_W'(i)) begin
                    r_rd_mask[i] <= instr_rd_hazards_i;
                    r_wr_mask[i] <= instr_wr_hazards_i;
                end
            end
        end
    end

    // Dispatch register: load on accept, drain on issue_ready_i, else hold
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_issue_valid <= 1'b0;
            r_issue_id    <= '0;
            r_issue_unit  <= UNIT_ALU;
        end else if (w_accept) begin
            r_issue_valid <= 1'b1;
            r_issue_id    <= w_free_idx;
            r_issue_unit  <= instr_unit_i;
        end else if (issue_ready_i) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign instr_ready_o = w_accept;
    assign stall_o       = instr_valid_i & ~w_accept;
    assign issue_valid_o = r_issue_valid;
    assign issue_id_o    = r_issue_id;
    assign issue_unit_o  = r_issue_unit;
    assign pend_rd_o     = w_pend_rd;
    assign pend_wr_o     = w_pend_wr;
    assign idle_o        = w_all_free & ~r_issue_valid;

    // A stalled requester must keep presenting its instruction
    a_valid_held : assert property (@(posedge clk_i) disable iff (async_rst_i)
        (instr_valid_i && !instr_ready_o) |=> instr_valid_i);

endmodule

// File: tb/tb_vproc_issue_scoreboard.sv
// Bench for vproc_issue_scoreboard: directed sequences, a hazard vector table
// and a randomized run against a slot-level reference model.

module tb_vproc_issue_scoreboard;
    import vproc_issue_pkg::*;

    localparam int MAXI = 4;
    localparam int IDW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           instr_valid = 1'b0;
    logic           instr_ready;
    op_unit         instr_unit = UNIT_ALU;
    logic [31:0]    rd_in = '0;
    logic [31:0]    wr_in = '0;
    logic           issue_valid;
    logic           issue_ready = 1'b0;
    op_unit         issue_unit;
    logic [IDW-1:0] issue_id;
    logic           rdone_v = 1'b0;
    logic [IDW-1:0] rdone_id = '0;
    logic           wdone_v = 1'b0;
    logic [IDW-1:0] wdone_id = '0;
    logic [31:0]    pend_rd;
    logic [31:0]    pend_wr;
    logic           stall;
    logic           idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vproc_issue_scoreboard #(.MAX_INFLIGHT(MAXI), .ID_W(IDW)) dut (
        .clk_i(clk), .async_rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_unit_i(instr_unit), .instr_rd_hazards_i(rd_in),
        .instr_wr_hazards_i(wr_in),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_unit_o(issue_unit), .issue_id_o(issue_id),
        .rdone_valid_i(rdone_v), .rdone_id_i(rdone_id),
        .wdone_valid_i(wdone_v), .wdone_id_i(wdone_id),
        .pend_rd_o(pend_rd), .pend_wr_o(pend_wr),
        .stall_o(stall), .idle_o(idle)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wr;
        logic        exp_rdy;
    } vec_t;
    vec_t vecs[8];

    // Reference model: per slot, "still holds reads" / "still holds writes"
    bit          m_hr  [MAXI];
    bit          m_hw  [MAXI];
    logic [31:0] m_rdm [MAXI];
    logic [31:0] m_wrm [MAXI];
    bit          m_iv;
    int          m_iid;
    op_unit      m_iu;
    bit          m_acc;
    int          m_fidx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input op_unit u, input logic [31:0] rd, input logic [31:0] wr);
        instr_valid = v;
        instr_unit  = u;
        rd_in       = rd;
        wr_in       = wr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        issue_ready = 1'b0;
        rdone_v = 1'b0; wdone_v = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < MAXI; i++) begin
            m_hr[i] = 0; m_hw[i] = 0; m_rdm[i] = '0; m_wrm[i] = '0;
        end
        m_iv = 0; m_iid = 0; m_iu = UNIT_ALU;
    endtask

    task automatic model_check();
        logic [31:0] pr, pw;
        bit anyf, conf, allf;
        pr = '0; pw = '0; anyf = 0; allf = 1; m_fidx = 0;
        for (int i = 0; i < MAXI; i++) begin
            if (m_hr[i]) pr |= m_rdm[i];
            if (m_hw[i]) begin
                pw |= m_wrm[i];
                allf = 0;
            end else if (!anyf) begin
                anyf = 1;
                m_fidx = i;
            end
        end
        conf  = ((rd_in & pw) != 0) || ((wr_in & pw) != 0) || ((wr_in & pr) != 0);
        m_acc = instr_valid && !conf && anyf && (!m_iv || issue_ready);
        chk("rnd_ready",  32'(instr_ready), 32'(m_acc));
        chk("rnd_stall",  32'(stall), 32'(instr_valid && !m_acc));
        chk("rnd_idle",   32'(idle), 32'(allf && !m_iv));
        chk("rnd_pend_rd", pend_rd, pr);
        chk("rnd_pend_wr", pend_wr, pw);
        chk("rnd_iv",     32'(issue_valid), 32'(m_iv));
        chk("rnd_iid",    32'(issue_id), 32'(m_iid));
        chk("rnd_iunit",  32'(issue_unit), 32'(m_iu));
    endtask

    task automatic model_update();
        if (wdone_v && int'(wdone_id) < MAXI) begin
            m_hr[wdone_id] = 0;
            m_hw[wdone_id] = 0;
        end
        if (rdone_v && int'(rdone_id) < MAXI) m_hr[rdone_id] = 0;
        if (m_acc) begin
            m_hr[m_fidx] = 1; m_hw[m_fidx] = 1;
            m_rdm[m_fidx] = rd_in; m_wrm[m_fidx] = wr_in;
            m_iv = 1; m_iid = m_fidx; m_iu = instr_unit;
        end else if (issue_ready) begin
            m_iv = 0;
        end
    endtask

    function automatic logic [31:0] rand_mask();
        logic [31:0] one;
        one = 32'h1;
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1, 2: return one << $urandom_range(0, 7);
            default: return (one << $urandom_range(0, 7)) | (one << $urandom_range(24, 31));
        endcase
    endfunction

    initial begin
        logic [31:0] one;
        one = 32'h1;

        // Reset state
        do_reset();
        #1;
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_iv", 32'(issue_valid), 32'd0);
        chk("rst_pend_wr", pend_wr, 32'h0);

        // 1: reset mid-operation
        issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, UNIT_MUL, 32'h0, one << k);
            tick();
        end
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t1_pre_pend_wr", pend_wr, 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("t1_iv", 32'(issue_valid), 32'd0);
        chk("t1_iid", 32'(issue_id), 32'd0);
        chk("t1_iunit", 32'(issue_unit), 32'd0);
        chk("t1_pend_rd", pend_rd, 32'h0);
        chk("t1_pend_wr", pend_wr, 32'h0);
        chk("t1_idle", 32'(idle), 32'd1);
        rst = 1'b0;

        // 2: RAW
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, UNIT_ALU, 32'h0, 32'h10);
        #1 chk("t2_ready0", 32'(instr_ready), 32'd1);
        tick();
        chk("t2_iv0", 32'(issue_valid), 32'd1);
        chk("t2_iid0", 32'(issue_id), 32'd0);
        drive(1'b1, UNIT_LSU, 32'h10, 32'h0);
        #1 chk("t2_stall", 32'(stall), 32'd1);
        tick();
        wdone_v = 1'b1; wdone_id = 3'd0;
        #1 chk("t2_stall_rel", 32'(stall), 32'd1);
        tick();
        wdone_v = 1'b0;
        #1 chk("t2_ready1", 32'(instr_ready), 32'd1);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t2_iv1", 32'(issue_valid), 32'd1);
        chk("t2_iid1", 32'(issue_id), 32'd0);
        chk("t2_iunit1", 32'(issue_unit), 32'(UNIT_LSU));

        // 3: WAR with early read release
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, UNIT_MUL, 32'h0000_0F00, 32'h1);
        tick();
        drive(1'b1, UNIT_LSU, 32'h0, 32'h0000_0100);
        #1 chk("t3_stall", 32'(stall), 32'd1);
        tick();
        rdone_v = 1'b1; rdone_id = 3'd0;
        #1 chk("t3_stall_rel", 32'(stall), 32'd1);
        tick();
        rdone_v = 1'b0;
        #1 chk("t3_ready", 32'(instr_ready), 32'd1);
        chk("t3_pend_wr", pend_wr, 32'h1);
        chk("t3_pend_rd", pend_rd, 32'h0);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t3_iid", 32'(issue_id), 32'd1);
        chk("t3_pend_wr2", pend_wr, 32'h101);

        // Hazard vector table against one ACTIVE entry rd=0xF00 wr=0x1
        vecs[0] = '{rd: 32'h0000_0001, wr: 32'h0,         exp_rdy: 1'b0};
        vecs[1] = '{rd: 32'h0,         wr: 32'h0000_0001, exp_rdy: 1'b0};
        vecs[2] = '{rd: 32'h0,         wr: 32'h0000_0100, exp_rdy: 1'b0};
        vecs[3] = '{rd: 32'h0000_0100, wr: 32'h0,         exp_rdy: 1'b1};
        vecs[4] = '{rd: 32'h0000_00F0, wr: 32'h0000_00F0, exp_rdy: 1'b1};
        vecs[5] = '{rd: 32'h0,         wr: 32'h0,         exp_rdy: 1'b1};
        vecs[6] = '{rd: 32'h8000_0000, wr: 32'h0000_0002, exp_rdy: 1'b1};
        vecs[7] = '{rd: 32'h0000_0002, wr: 32'h0000_0800, exp_rdy: 1'b0};
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, UNIT_ALU, 32'h0000_0F00, 32'h1);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        for (int v = 0; v < 8; v++) begin
            drive(1'b1, UNIT_ELEM, vecs[v].rd, vecs[v].wr);
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(instr_ready), 32'(vecs[v].exp_rdy));
            chk($sformatf("vec%0d_stall", v), 32'(stall), 32'(!vecs[v].exp_rdy));
            #1 instr_valid = 1'b0;
            tick();
        end

        // 4: full and back-to-back
        do_reset();
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, UNIT_ALU, 32'h0, one << k);
            #1 chk($sformatf("t4_ready%0d", k), 32'(instr_ready), 32'd1);
            tick();
            chk($sformatf("t4_iv%0d", k), 32'(issue_valid), 32'd1);
            chk($sformatf("t4_iid%0d", k), 32'(issue_id), 32'(k));
        end
        drive(1'b1, UNIT_ELEM, 32'h0, 32'h100);
        #1 chk("t4_full_stall", 32'(stall), 32'd1);
        tick();
        chk("t4_drained", 32'(issue_valid), 32'd0);
        wdone_v = 1'b1; wdone_id = 3'd2;
        #1 chk("t4_full_rel", 32'(instr_ready), 32'd0);
        tick();
        wdone_v = 1'b0;
        #1 chk("t4_ready5", 32'(instr_ready), 32'd1);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t4_iid5", 32'(issue_id), 32'd2);
        chk("t4_iunit5", 32'(issue_unit), 32'(UNIT_ELEM));

        // 5: dispatch backpressure
        do_reset();
        issue_ready = 1'b0;
        drive(1'b1, UNIT_MUL, 32'h0, 32'h1);
        tick();
        drive(1'b1, UNIT_LSU, 32'h0, 32'h2);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t5_ready", 32'(instr_ready), 32'd0);
            chk("t5_iv", 32'(issue_valid), 32'd1);
            chk("t5_iid", 32'(issue_id), 32'd0);
            chk("t5_iunit", 32'(issue_unit), 32'(UNIT_MUL));
            tick();
        end
        issue_ready = 1'b1;
        #1 chk("t5_ready_rel", 32'(instr_ready), 32'd1);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t5_iv2", 32'(issue_valid), 32'd1);
        chk("t5_iid2", 32'(issue_id), 32'd1);
        chk("t5_iunit2", 32'(issue_unit), 32'(UNIT_LSU));

        // 6: simultaneous and illegal releases
        do_reset();
        issue_ready = 1'b1;
        drive(1'b1, UNIT_ALU, 32'h1, 32'h2);
        tick();
        drive(1'b1, UNIT_ALU, 32'h4, 32'h8);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t6_pend_rd0", pend_rd, 32'h5);
        chk("t6_pend_wr0", pend_wr, 32'hA);
        rdone_v = 1'b1; rdone_id = 3'd1; wdone_v = 1'b1; wdone_id = 3'd1;
        tick();
        rdone_v = 1'b0; wdone_v = 1'b0;
        chk("t6_pend_rd1", pend_rd, 32'h1);
        chk("t6_pend_wr1", pend_wr, 32'h2);
        drive(1'b1, UNIT_MUL, 32'h0, 32'h10);
        tick();
        drive(1'b0, UNIT_ALU, 32'h0, 32'h0);
        chk("t6_reuse_id", 32'(issue_id), 32'd1);
        rdone_v = 1'b1; rdone_id = 3'd2; wdone_v = 1'b1; wdone_id = 3'd7;
        tick();
        rdone_v = 1'b1; rdone_id = 3'd5; wdone_v = 1'b1; wdone_id = 3'd3;
        tick();
        rdone_v = 1'b0; wdone_v = 1'b0;
        chk("t6_pend_rd2", pend_rd, 32'h1);
        chk("t6_pend_wr2", pend_wr, 32'h12);

        // Randomized run against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(instr_valid && !m_acc)) begin
                drive($urandom_range(0, 9) < 6, op_unit'($urandom_range(0, 3)),
                      rand_mask(), rand_mask());
            end
            issue_ready = $urandom_range(0, 9) < 7;
            rdone_v  = $urandom_range(0, 9) < 3;
            rdone_id = ($urandom_range(0, 4) == 0) ? IDW'($urandom_range(0, 7)) : IDW'($urandom_range(0, 3));
            wdone_v  = $urandom_range(0, 9) < 3;
            wdone_id = ($urandom_range(0, 4) == 0) ? IDW'($urandom_range(0, 7)) : IDW'($urandom_range(0, 3));
            #1;
            model_check();
            tick();
            model_update();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
